spi_master_tx: RTL and testbench
================================

SPI_MASTER_TX -- requirements
Module: spi_master_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the bits per SPI word (legal range 2..32).
REQ-002 The block SHALL have parameter CLK_DIV, default 4, giving the SCLK half-period in clk_in cycles (legal range 1..255).
REQ-003 The block SHALL have port clk_in  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n_in  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port data_in  input  DATA_WIDTH  parallel word to transmit, MSB first.
REQ-006 The block SHALL have port valid_in  input  1  data_in is valid.
REQ-007 The block SHALL have port ready_out  output  1  block can accept a word.
REQ-008 The block SHALL have port sclk_out  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-009 The block SHALL have port mosi_out  output  1  serial data out.
REQ-010 The block SHALL have port cs_n_out  output  1  chip select, active-low.
REQ-011 The block SHALL have port done_out  output  1  one-cycle pulse at end of transfer.
REQ-012 The block SHALL have port miso_in  input  1  serial data in.
REQ-013 The block SHALL have port rx_data_out  output  DATA_WIDTH  received word.
REQ-014 The block SHALL have port rx_valid_out  output  1  one-cycle pulse, rx_data_out valid.

Function
REQ-015 The block SHALL accept a word on any rising edge of clk_in where valid_in and ready_out are both 1; the accept cycle is cycle 0.
REQ-016 The FSM SHALL have states IDLE, LEAD, SHIFT and TRAIL; ready_out SHALL be 1 only in IDLE.
REQ-017 IDLE->LEAD on accept; from cycle 1, cs_n_out=0 and mosi_out=data_in[DATA_WIDTH-1].
REQ-018 LEAD SHALL last CLK_DIV cycles with sclk_out=0, then go to SHIFT.
REQ-019 SHIFT SHALL emit DATA_WIDTH SCLK periods, each CLK_DIV cycles high followed by CLK_DIV cycles low.
REQ-020 miso_in SHALL be sampled on each SCLK rising transition (sclk_out 0->1); mosi_out SHALL advance to the next lower bit on each falling transition, except the last.
REQ-021 An internal bit counter SHALL count 0..DATA_WIDTH-1 and SHALL NOT wrap; after the DATA_WIDTH-th falling transition the FSM SHALL go to TRAIL.
REQ-022 TRAIL SHALL last CLK_DIV cycles with sclk_out=0 and cs_n_out=0, then return to IDLE.
REQ-023 On the first IDLE cycle after TRAIL: cs_n_out=1, mosi_out=0, done_out=1 for exactly one cycle, and ready_out=1.
REQ-024 Busy time SHALL be (2*DATA_WIDTH+2)*CLK_DIV cycles from cycle 1 through the end of TRAIL; the defaults give 72 cycles.
REQ-025 valid_in while ready_out=0 SHALL be ignored, and data_in SHALL be captured only on accept.
REQ-026 An accept in the same cycle as done_out=1 SHALL be legal and SHALL start LEAD on the next cycle (back-to-back, cs_n_out stays high for exactly 1 cycle).
REQ-027 In IDLE, outputs SHALL hold sclk_out=0, cs_n_out=1, mosi_out=0.

Reset
REQ-028 When rst_n_in=0 at a rising edge, on the next cycle: FSM=IDLE, ready_out=1, sclk_out=0, mosi_out=0, cs_n_out=1, done_out=0, rx_data_out=0, rx_valid_out=0, counters=0.
REQ-029 Reset mid-transfer SHALL abort without done_out or rx_valid_out pulses, and the partial word SHALL be discarded.
REQ-030 valid_in while rst_n_in=0 SHALL NOT be accepted.

Configuration
REQ-031 Macro SPI_MASTER_RX_EN SHALL control the receive path.
REQ-032 With SPI_MASTER_RX_EN defined: MISO SHALL be shifted into rx_data_out MSB first per REQ-020, and rx_valid_out SHALL pulse in the same cycle as done_out with rx_data_out holding the received word until the next rx_valid_out.
REQ-033 Without SPI_MASTER_RX_EN: miso_in SHALL be ignored and rx_data_out and rx_valid_out SHALL be constant 0, with the port list unchanged and TX behaviour identical.

Verification
REQ-034 Reset then idle: rst_n_in=0 for 2 cycles -> ready_out=1, cs_n_out=1, sclk_out=0, mosi_out=0, done_out=0.
REQ-035 Defaults, send 0xA5 with miso_in tied to a slave echoing 0x3C -> MOSI samples at 8 rising edges = 1,0,1,0,0,1,0,1; done_out at cycle 73; rx_data_out=0x3C (RX_EN).
REQ-036 CLK_DIV=1, DATA_WIDTH=8, send 0xFF then 0x00 back-to-back -> two frames, each with 18 busy cycles, and cs_n_out high for exactly 1 cycle between them.
REQ-037 valid_in=1 with data_in=0x12 held during a 0x81 transfer -> 0x81 transmitted intact; 0x12 accepted only at the done_out cycle.
REQ-038 Assert rst_n_in=0 after the 4th SCLK rise of 0xC3 -> next cycle IDLE outputs, no done_out/rx_valid_out; a subsequent 0x5A transfers correctly.
REQ-039 Build without SPI_MASTER_RX_EN, send 0x96 with miso_in=1 -> rx_data_out=0, rx_valid_out never 1, MOSI sequence 1,0,0,1,0,1,1,0.

Source files
------------

// File: rtl/spi_master_tx.sv
// -----------------------------------------------------------------------------
// spi_master_tx
//
// SPI master (mode 0: CPOL=0, CPHA=0) that transmits one DATA_WIDTH-bit word
// MSB first per accepted request. It can optionally receive a word on MISO
// during the same frame.
//
// Optional feature macro: SPI_MASTER_RX_EN
//   defined   - MISO is shifted in MSB first on every SCLK rising transition.
//               rx_valid_out pulses together with done_out.
//   undefined - miso_in is ignored, and rx_data_out / rx_valid_out are tied to 0.
//
// Parameters
//   DATA_WIDTH  bits per SPI word (2..32)
//   CLK_DIV     SCLK half-period in clk_in cycles (1..255)
//
// Ports
//   clk_in        system clock, rising edge
//   rst_n_in      synchronous active-low reset
//   data_in       word to transmit, captured on accept
//   valid_in      data_in is valid; accepted when ready_out=1
//   ready_out     block is idle and can accept a word
//   sclk_out      SPI clock
//   mosi_out      serial data out
//   cs_n_out      chip select, active-low
//   done_out      one-cycle pulse on the first idle cycle after a frame
//   miso_in       serial data in
//   rx_data_out   last received word
//   rx_valid_out  one-cycle pulse, rx_data_out updated
//
// Frame timing, where cycle 1 is the cycle after accept:
//   LEAD  CLK_DIV cycles, sclk low
//   SHIFT DATA_WIDTH x (CLK_DIV high + CLK_DIV low)
//   TRAIL CLK_DIV cycles, sclk low
//   The first IDLE cycle that follows carries done_out.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | cs_n high, ready for a word, done pulse on entry
// LEAD  | cs_n low, MSB on mosi, waiting before the first SCLK rise
// SHIFT | toggling SCLK, one bit per period
// TRAIL | cs_n still low, hold time after the last SCLK period
// -----------------------------------------------------------------------------
module spi_master_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic                  sclk_out,
    output logic                  mosi_out,
    output logic                  cs_n_out,
    output logic                  done_out,
    input  logic                  miso_in,
    output logic [DATA_WIDTH-1:0] rx_data_out,
    output logic                  rx_valid_out
);

    localparam int BIT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [7:0]       DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } state_t;

    state_t                state;
    logic [7:0]            div_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] tx_sh;

    logic tc;
    logic last_bit;

    // Half-period timer: a down-counter reloaded with CLK_DIV-1 on every phase change.
    assign tc       = (div_cnt == 8'd0);
    assign last_bit = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state     <= IDLE;
            div_cnt   <= 8'd0;
            bit_cnt   <= '0;
            tx_sh     <= '0;
            ready_out <= 1'b1;
            sclk_out  <= 1'b0;
            mosi_out  <= 1'b0;
            cs_n_out  <= 1'b1;
            done_out  <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        state     <= LEAD;
                        div_cnt   <= DIV_LOAD;
                        bit_cnt   <= '0;
                        // Keep the bits that follow the MSB, so that each falling edge takes the top bit.
                        tx_sh     <= {data_in[DATA_WIDTH-2:0], 1'b0};
                        mosi_out  <= data_in[DATA_WIDTH-1];
                        cs_n_out  <= 1'b0;
                        ready_out <= 1'b0;
                    end
                end
                LEAD: begin
                    if (tc) begin
                        state    <= SHIFT;
                        sclk_out <= 1'b1;
                        div_cnt  <= DIV_LOAD;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                SHIFT: begin
                    if (!tc) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else if (sclk_out) begin
                        // Falling transition. The LSB is held through the last low phase and TRAIL.
                        sclk_out <= 1'b0;
                        div_cnt  <= DIV_LOAD;
                        if (!last_bit) begin
                            mosi_out <= tx_sh[DATA_WIDTH-1];
                            tx_sh    <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
                        end
                    end else if (last_bit) begin
                        state   <= TRAIL;
                        div_cnt <= DIV_LOAD;
                    end else begin
                        bit_cnt  <= bit_cnt + 1'b1;
                        sclk_out <= 1'b1;
                        div_cnt  <= DIV_LOAD;
                    end
                end
                TRAIL: begin
                    if (tc) begin
                        state     <= IDLE;
                        cs_n_out  <= 1'b1;
                        mosi_out  <= 1'b0;
                        done_out  <= 1'b1;
                        ready_out <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_MASTER_RX_EN
    logic                  rise_evt;
    logic                  end_evt;
    logic [DATA_WIDTH-1:0] rx_sh;

    // Same edges on which the FSM drives sclk_out from 0 to 1.
    assign rise_evt = tc && ((state == LEAD) || ((state == SHIFT) && !sclk_out && !last_bit));
    assign end_evt  = tc && (state == TRAIL);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            rx_sh        <= '0;
            rx_data_out  <= '0;
            rx_valid_out <= 1'b0;
        end else begin
            rx_valid_out <= 1'b0;
            if (rise_evt) begin
                rx_sh <= {rx_sh[DATA_WIDTH-2:0], miso_in};
            end
            // Publish only on a completed frame; an aborted partial word never reaches the port.
            if (end_evt) begin
                rx_data_out  <= rx_sh;
                rx_valid_out <= 1'b1;
            end
        end
    end
`else
    logic unused_miso;
    assign unused_miso  = miso_in;
    assign rx_data_out  = '0;
    assign rx_valid_out = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
module tb_spi_master_tx;

    localparam int DW  = 8;
    localparam int CD0 = 4;
    localparam int CD1 = 1;
`ifdef SPI_MASTER_RX_EN
    localparam bit RX_EN = 1'b1;
`else
    localparam bit RX_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [DW-1:0] data   [2];
    logic          valid  [2];
    logic          miso   [2];
    logic          ready  [2];
    logic          sclk   [2];
    logic          mosi   [2];
    logic          cs_n   [2];
    logic          done   [2];
    logic          rxv    [2];
    logic [DW-1:0] rxd    [2];

    spi_master_tx #(.DATA_WIDTH(DW), .CLK_DIV(CD0)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(data[0]), .valid_in(valid[0]),
        .ready_out(ready[0]), .sclk_out(sclk[0]), .mosi_out(mosi[0]), .cs_n_out(cs_n[0]),
        .done_out(done[0]), .miso_in(miso[0]), .rx_data_out(rxd[0]), .rx_valid_out(rxv[0])
    );

    spi_master_tx #(.DATA_WIDTH(DW), .CLK_DIV(CD1)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(data[1]), .valid_in(valid[1]),
        .ready_out(ready[1]), .sclk_out(sclk[1]), .mosi_out(mosi[1]), .cs_n_out(cs_n[1]),
        .done_out(done[1]), .miso_in(miso[1]), .rx_data_out(rxd[1]), .rx_valid_out(rxv[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cdiv(input int i);
        return (i == 0) ? CD0 : CD1;
    endfunction

    function automatic int busy_len(input int i);
        return (2 * DW + 2) * cdiv(i);
    endfunction

    // ---------------- behavioural model ----------------
    bit            m_known [2];
    bit            m_busy  [2];
    int            m_t     [2];
    logic [DW-1:0] m_word  [2];
    bit            m_done  [2];
    logic [DW-1:0] m_rx    [2];
    logic [DW-1:0] echo    [2];
    bit            m_rdy;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_known[i] = 1'b1;
                m_busy[i]  = 1'b0;
                m_t[i]     = 0;
                m_done[i]  = 1'b0;
                m_rx[i]    = '0;
            end else if (m_known[i]) begin
                m_rdy     = !m_busy[i];
                m_done[i] = 1'b0;
                if (m_busy[i]) begin
                    m_t[i]++;
                    if (m_t[i] > busy_len(i)) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                        m_rx[i]   = echo[i];
                    end
                end
                if (m_rdy && valid[i]) begin
                    m_busy[i] = 1'b1;
                    m_t[i]    = 1;
                    m_word[i] = data[i];
                end
            end
        end
    end

    task automatic model_out(input int i, output logic e_rdy, output logic e_cs,
                             output logic e_sclk, output logic e_mosi, output logic e_done);
        int t, cd, s, b;
        logic [DW-1:0] w;
        w  = m_word[i];
        cd = cdiv(i);
        t  = m_t[i];
        if (!m_busy[i]) begin
            e_rdy = 1'b1; e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_done = m_done[i];
        end else begin
            e_rdy = 1'b0; e_cs = 1'b0; e_done = 1'b0;
            if (t <= cd) begin
                e_sclk = 1'b0;
                e_mosi = w[DW-1];
            end else if (t <= cd + 2 * DW * cd) begin
                s = t - cd - 1;
                b = s / (2 * cd);
                e_sclk = ((s % (2 * cd)) < cd);
                if (e_sclk)            e_mosi = w[DW-1-b];
                else if (b == DW - 1)  e_mosi = w[0];
                else                   e_mosi = w[DW-2-b];
            end else begin
                e_sclk = 1'b0;
                e_mosi = w[0];
            end
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic e_rdy, e_cs, e_sclk, e_mosi, e_done;
        for (int i = 0; i < 2; i++) begin
            if (m_known[i]) begin
                model_out(i, e_rdy, e_cs, e_sclk, e_mosi, e_done);
                chk($sformatf("dut%0d ready", i), {31'b0, ready[i]}, {31'b0, e_rdy});
                chk($sformatf("dut%0d cs_n", i),  {31'b0, cs_n[i]},  {31'b0, e_cs});
                chk($sformatf("dut%0d sclk", i),  {31'b0, sclk[i]},  {31'b0, e_sclk});
                chk($sformatf("dut%0d mosi", i),  {31'b0, mosi[i]},  {31'b0, e_mosi});
                chk($sformatf("dut%0d done", i),  {31'b0, done[i]},  {31'b0, e_done});
                chk($sformatf("dut%0d rx_valid", i), {31'b0, rxv[i]}, {31'b0, RX_EN & e_done});
                chk($sformatf("dut%0d rx_data", i), {24'b0, rxd[i]}, {24'b0, RX_EN ? m_rx[i] : 8'h00});
            end
        end
    end

    // ---------------- SPI slave echo + MOSI capture ----------------
    logic          prev_sclk [2];
    logic          prev_cs   [2];
    int            k_bit     [2];
    logic [DW-1:0] cap       [2];
    int            cap_cnt   [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (prev_cs[i] === 1'b1 && cs_n[i] === 1'b0) begin
                cap[i]     = '0;
                cap_cnt[i] = 0;
            end
            if (prev_sclk[i] === 1'b0 && sclk[i] === 1'b1) begin
                cap[i] = {cap[i][DW-2:0], mosi[i]};
                cap_cnt[i]++;
            end
            if (cs_n[i] !== 1'b0)
                k_bit[i] = 0;
            else if (prev_sclk[i] === 1'b1 && sclk[i] === 1'b0)
                k_bit[i]++;
            miso[i]      = (k_bit[i] < DW) ? echo[i][DW-1-k_bit[i]] : 1'b0;
            prev_sclk[i] = sclk[i];
            prev_cs[i]   = cs_n[i];
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int i, input logic [DW-1:0] w, input logic [DW-1:0] e, output int n);
        @(negedge clk);
        echo[i]  = e;
        data[i]  = w;
        valid[i] = 1'b1;
        n = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            valid[i] = 1'b0;
            n++;
            if (done[i] === 1'b1) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n1, n2, gap;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0; data[i] = '0; echo[i] = '0; miso[i] = 1'b0;
            m_known[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_t[i] = 0;
            m_word[i] = '0; m_rx[i] = '0;
            prev_sclk[i] = 1'b0; prev_cs[i] = 1'b1; k_bit[i] = 0; cap[i] = '0; cap_cnt[i] = 0;
        end
        valid[0] = 1'b1;
        data[0]  = 8'h77;

        // Reset held for 2 cycles with valid_in high, then idle values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready", {31'b0, ready[0]}, 32'd1);
        chk("reset cs_n",  {31'b0, cs_n[0]},  32'd1);
        chk("reset sclk",  {31'b0, sclk[0]},  32'd0);
        chk("reset mosi",  {31'b0, mosi[0]},  32'd0);
        chk("reset done",  {31'b0, done[0]},  32'd0);
        chk("reset rx_data", {24'b0, rxd[0]}, 32'd0);
        valid[0] = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 0xA5 at the default settings, with the slave echoing 0x3C.
        send(0, 8'hA5, 8'h3C, n);
        chk("a5 done cycle", n, 32'd73);
        chk("a5 mosi bits", {24'b0, cap[0]}, 32'hA5);
        chk("a5 rise count", cap_cnt[0], 32'd8);
        chk("a5 rx_data", {24'b0, rxd[0]}, RX_EN ? 32'h3C : 32'h0);
        repeat (2) @(negedge clk);

        // CLK_DIV=1: 0xFF then 0x00 back-to-back.
        @(negedge clk);
        echo[1] = 8'h0F; data[1] = 8'hFF; valid[1] = 1'b1;
        @(negedge clk);
        data[1] = 8'h00;
        n1 = 0;
        for (int k = 0; k < 400; k++) begin
            if (cs_n[1] !== 1'b0) break;
            n1++;
            @(negedge clk);
        end
        chk("b2b frame1 busy", n1, 32'd18);
        chk("b2b frame1 bits", {24'b0, cap[1]}, 32'hFF);
        gap = 0;
        for (int k = 0; k < 400; k++) begin
            if (cs_n[1] !== 1'b1) break;
            gap++;
            @(negedge clk);
        end
        chk("b2b cs_n gap", gap, 32'd1);
        valid[1] = 1'b0;
        n2 = 0;
        for (int k = 0; k < 400; k++) begin
            if (cs_n[1] !== 1'b0) break;
            n2++;
            @(negedge clk);
        end
        chk("b2b frame2 busy", n2, 32'd18);
        chk("b2b frame2 bits", {24'b0, cap[1]}, 32'h00);
        repeat (2) @(negedge clk);

        // valid_in held with 0x12 during a 0x81 frame.
        @(negedge clk);
        echo[0] = 8'h5A; data[0] = 8'h81; valid[0] = 1'b1;
        @(negedge clk);
        data[0] = 8'h12;
        n = 1;
        for (int k = 0; k < 400; k++) begin
            if (done[0] === 1'b1) break;
            @(negedge clk);
            n++;
        end
        chk("hold 0x81 done cycle", n, 32'd73);
        chk("hold 0x81 bits", {24'b0, cap[0]}, 32'h81);
        @(negedge clk);
        chk("hold 0x12 accepted at done", {31'b0, cs_n[0]}, 32'd0);
        valid[0] = 1'b0;
        n = 1;
        for (int k = 0; k < 400; k++) begin
            if (done[0] === 1'b1) break;
            @(negedge clk);
            n++;
        end
        chk("hold 0x12 done cycle", n, 32'd73);
        chk("hold 0x12 bits", {24'b0, cap[0]}, 32'h12);
        repeat (2) @(negedge clk);

        // Reset after the 4th SCLK rise of 0xC3.
        @(negedge clk);
        echo[0] = 8'h99; data[0] = 8'hC3; valid[0] = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            #1;
            valid[0] = 1'b0;
            if (cap_cnt[0] == 4) break;
        end
        chk("abort rise count", cap_cnt[0], 32'd4);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort cs_n", {31'b0, cs_n[0]}, 32'd1);
        chk("abort sclk", {31'b0, sclk[0]}, 32'd0);
        chk("abort mosi", {31'b0, mosi[0]}, 32'd0);
        chk("abort done", {31'b0, done[0]}, 32'd0);
        chk("abort rx_valid", {31'b0, rxv[0]}, 32'd0);
        chk("abort ready", {31'b0, ready[0]}, 32'd1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send(0, 8'h5A, 8'hA5, n);
        chk("after abort done cycle", n, 32'd73);
        chk("after abort bits", {24'b0, cap[0]}, 32'h5A);
        chk("after abort rx_data", {24'b0, rxd[0]}, RX_EN ? 32'hA5 : 32'h0);
        repeat (2) @(negedge clk);

        // 0x96 with miso_in held at 1.
        send(0, 8'h96, 8'hFF, n);
        chk("0x96 done cycle", n, 32'd73);
        chk("0x96 bits", {24'b0, cap[0]}, 32'h96);
        chk("0x96 rx_data", {24'b0, rxd[0]}, RX_EN ? 32'hFF : 32'h0);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
